// File: rtl/ariane_pkg.sv
// -----------------------------------------------------------------------------
// ariane_pkg
// Shared frontend/decode types used by the fetch entry queue.
//   cf_t                : control-flow class of a predicted instruction
//   branchpredict_sbe_t : prediction record carried with each fetch entry
//   exception_t         : exception record (cause, tval, valid)
//   fetch_entry_t       : one realigned instruction handed to decode
// -----------------------------------------------------------------------------
package ariane_pkg;

    typedef enum logic [2:0] {
        NoCF,
        Branch,
        Jump,
        JumpR,
        Return
    } cf_t;

    typedef struct packed {
        cf_t         cf;
        logic [63:0] predict_address;
    } branchpredict_sbe_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0]        address;
        logic [31:0]        instruction;
        branchpredict_sbe_t branch_predict;
        exception_t         ex;
    } fetch_entry_t;

endpackage

// File: rtl/config_pkg.sv
// -----------------------------------------------------------------------------
// config_pkg
// Core configuration slice shared by the frontend blocks. Only the fields the
// fetch path consults are carried here.
//   cva6_cfg_t     : packed core configuration record
//   cva6_cfg_empty : neutral default configuration (all fields zero)
// -----------------------------------------------------------------------------
package config_pkg;

    typedef struct packed {
        int unsigned VLEN;
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/fetch_entry_queue.sv
// -----------------------------------------------------------------------------
// fetch_entry_queue
// Circular-buffer FIFO between the frontend realigner and decode. Entries are
// delivered in strict FIFO order. Once an entry carrying an exception is
// accepted, further pushes are blocked until a flush; stored entries, including
// the faulting one, still drain. A flush empties the queue at the next edge.
//
// Optional feature (macro FETCH_QUEUE_BYPASS_EN): when the queue is empty, not
// flushing and not locked, entry_i is forwarded combinationally to decode and
// is not stored if decode accepts it in the same cycle.
//
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   flush_i                : controller flush
//   entry_i, entry_valid_i : entry from the realigner and its valid
//   entry_ready_o          : queue accepts entry_i this cycle
//   fetch_entry_o          : oldest entry presented to decode
//   fetch_entry_valid_o    : fetch_entry_o valid
//   fetch_entry_ready_i    : decode accepts fetch_entry_o
//   occupancy_o            : number of stored entries
// -----------------------------------------------------------------------------
module fetch_entry_queue
    import ariane_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned           DEPTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  fetch_entry_t          entry_i,
    input  logic                  entry_valid_i,
    output logic                  entry_ready_o,
    output fetch_entry_t          fetch_entry_o,
    output logic                  fetch_entry_valid_o,
    input  logic                  fetch_entry_ready_i,
    output logic [$clog2(DEPTH):0] occupancy_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    // Pointers wrap naturally because DEPTH is a power of two; the address
    // field of an entry must also be wide enough for the core's VLEN.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (CVA6Cfg.VLEN > 64)) begin : g_bad_cfg
        $error("fetch_entry_queue: DEPTH must be a power of two >= 2 and VLEN <= 64");
    end

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    last_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic            ex_lock_q;

    logic empty;
    logic full;
    logic bypass;
    logic push;
    logic pop;
    logic store;
    logic drain;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CntW'(DEPTH));
    assign occupancy_o = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && !flush_i && !ex_lock_q;
`else
    assign bypass = 1'b0;
`endif

    // Handshake and output selection. The ready does not look at decode's
    // ready, so a pop never frees a slot for a same-cycle push. When nothing
    // is stored (and no bypass), the output holds whatever it showed last.
    // A bypassed entry that decode takes at once is consumed without storing.
    always_comb begin
        entry_ready_o       = !full && !ex_lock_q && !flush_i;
        push                = entry_valid_i && entry_ready_o;
        fetch_entry_o       = last_q;
        fetch_entry_valid_o = 1'b0;
        if (bypass) begin
            fetch_entry_o       = entry_i;
            fetch_entry_valid_o = entry_valid_i;
        end else if (!empty) begin
            fetch_entry_o       = mem_q[rd_ptr_q];
            fetch_entry_valid_o = !flush_i;
        end
        pop   = fetch_entry_valid_o && fetch_entry_ready_i;
        store = push && !(bypass && pop);
        drain = pop && !bypass;
    end

    // Pointer, occupancy and exception-lock state. A flush wins over any
    // push/pop in its cycle (both are already suppressed combinationally).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ex_lock_q <= 1'b0;
        end else if (flush_i) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ex_lock_q <= 1'b0;
        end else begin
            if (store) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (drain) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({store, drain})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            if (push && entry_i.ex.valid) begin
                ex_lock_q <= 1'b1;
            end
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (store) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    // Remembers the presented entry so an empty queue keeps a stable, known
    // output instead of exposing a stale or unwritten slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= '0;
        end else begin
            last_q <= fetch_entry_o;
        end
    end

endmodule

// File: tb/tb_fetch_entry_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_entry_queue
// Self-checking bench for fetch_entry_queue (DEPTH=4). A queue-based model of
// the FIFO predicts every output each cycle; directed scenarios pin the model
// with literal expectations, then randomized traffic with flushes, exceptions
// and asynchronous resets runs against it. Honors FETCH_QUEUE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_fetch_entry_queue;
    import ariane_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk_i               = 1'b0;
    logic             rst_ni              = 1'b0;
    logic             flush_i             = 1'b0;
    fetch_entry_t     entry_i             = '0;
    logic             entry_valid_i       = 1'b0;
    logic             entry_ready_o;
    fetch_entry_t     fetch_entry_o;
    logic             fetch_entry_valid_o;
    logic             fetch_entry_ready_i = 1'b0;
    logic [CNT_W-1:0] occupancy_o;

    fetch_entry_queue #(
        .CVA6Cfg(config_pkg::cva6_cfg_empty),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .flush_i            (flush_i),
        .entry_i            (entry_i),
        .entry_valid_i      (entry_valid_i),
        .entry_ready_o      (entry_ready_o),
        .fetch_entry_o      (fetch_entry_o),
        .fetch_entry_valid_o(fetch_entry_valid_o),
        .fetch_entry_ready_i(fetch_entry_ready_i),
        .occupancy_o        (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    int assertions = 0;
    int failures   = 0;

    // Reference model: stored entries oldest-first, lock flag, last output.
    fetch_entry_t model_q[$];
    bit           model_lock       = 1'b0;
    fetch_entry_t model_last       = '0;
    bit           model_last_known = 1'b0;

    bit           exp_ready, exp_valid, exp_bypass, exp_data_known;
    fetch_entry_t exp_data;

    logic             s_ready, s_valid;
    logic [CNT_W-1:0] s_occ;
    logic [63:0]      s_addr;
    logic [63:0]      popped[$];

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkEntry(input string name, input fetch_entry_t act, input fetch_entry_t exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got addr %0h instr %0h exv %0b, expected addr %0h instr %0h exv %0b (t=%0t)",
                     name, act.address, act.instruction, act.ex.valid,
                     exp.address, exp.instruction, exp.ex.valid, $time);
        end
    endtask

    function automatic fetch_entry_t mkEntry(input logic [63:0] addr, input bit exc);
        fetch_entry_t e;
        e.address                        = addr;
        e.instruction                    = $urandom;
        e.branch_predict.cf              = cf_t'($urandom_range(0, 4));
        e.branch_predict.predict_address = {$urandom, $urandom};
        e.ex.cause                       = {32'h0, $urandom};
        e.ex.tval                        = {$urandom, $urandom};
        e.ex.valid                       = exc;
        return e;
    endfunction

    // What the outputs must be right now, from the queue contents and inputs.
    task automatic computeExpected();
        exp_bypass = BYPASS && (model_q.size() == 0) && !flush_i && !model_lock;
        exp_ready  = (model_q.size() < DEPTH) && !model_lock && !flush_i;
        if (exp_bypass) begin
            exp_valid      = entry_valid_i;
            exp_data       = entry_i;
            exp_data_known = 1'b1;
        end else if (model_q.size() == 0) begin
            exp_valid      = 1'b0;
            exp_data       = model_last;
            exp_data_known = model_last_known;
        end else begin
            exp_valid      = !flush_i;
            exp_data       = model_q[0];
            exp_data_known = 1'b1;
        end
    endtask

    // Compares every output against the model and records accepted pops.
    task automatic checkOutput();
        computeExpected();
        s_ready = entry_ready_o;
        s_valid = fetch_entry_valid_o;
        s_occ   = occupancy_o;
        s_addr  = fetch_entry_o.address;
        check1("entry_ready_o", 64'(entry_ready_o), 64'(exp_ready));
        check1("fetch_entry_valid_o", 64'(fetch_entry_valid_o), 64'(exp_valid));
        check1("occupancy_o", 64'(occupancy_o), 64'(model_q.size()));
        if (exp_data_known) begin
            checkEntry("fetch_entry_o", fetch_entry_o, exp_data);
        end
        if (fetch_entry_valid_o && fetch_entry_ready_i) begin
            popped.push_back(fetch_entry_o.address);
        end
    endtask

    // Advances the model across one rising edge using the held inputs.
    task automatic updateModel();
        bit push, pop;
        push = entry_valid_i && exp_ready;
        pop  = exp_valid && fetch_entry_ready_i;
        if (flush_i) begin
            model_q.delete();
            model_lock = 1'b0;
        end else begin
            if (pop && !exp_bypass) void'(model_q.pop_front());
            if (push && !(exp_bypass && pop)) model_q.push_back(entry_i);
            if (push && entry_i.ex.valid) model_lock = 1'b1;
        end
        if (exp_data_known) begin
            model_last       = exp_data;
            model_last_known = 1'b1;
        end
    endtask

    task automatic applyStimulus(input bit v, input fetch_entry_t e, input bit rdy, input bit fl);
        @(negedge clk_i);
        entry_valid_i       = v;
        entry_i             = e;
        fetch_entry_ready_i = rdy;
        flush_i             = fl;
        #1;
        checkOutput();
        @(posedge clk_i);
        updateModel();
    endtask

    // Asserts reset in the middle of a cycle and checks it takes effect at once.
    task automatic midReset();
        @(negedge clk_i);
        entry_valid_i       = 1'b0;
        flush_i             = 1'b0;
        fetch_entry_ready_i = 1'($urandom_range(0, 1));
        #2 rst_ni = 1'b0;
        #1;
        check1("reset occupancy_o", 64'(occupancy_o), 64'd0);
        check1("reset fetch_entry_valid_o", 64'(fetch_entry_valid_o), 64'd0);
        check1("reset entry_ready_o", 64'(entry_ready_o), 64'd1);
        model_q.delete();
        model_lock       = 1'b0;
        model_last_known = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        fetch_entry_t exA;

        // Power-on reset
        repeat (2) @(negedge clk_i);
        #1;
        check1("por occupancy_o", 64'(occupancy_o), 64'd0);
        check1("por fetch_entry_valid_o", 64'(fetch_entry_valid_o), 64'd0);
        check1("por entry_ready_o", 64'(entry_ready_o), 64'd1);
        rst_ni = 1'b1;

        // Fill: five offered, four accepted
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, mkEntry(64'h8000_0000 + 64'(4 * i), 1'b0), 1'b0, 1'b0);
        check1("fill entry_ready_o", 64'(s_ready), 64'd0);
        check1("fill occupancy_o", 64'(s_occ), 64'd4);

        // Drain in order
        popped.delete();
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, mkEntry(64'h0, 1'b0), 1'b1, 1'b0);
        check1("drain count", 64'(popped.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < popped.size())
                check1("drain order", popped[i], 64'h8000_0000 + 64'(4 * i));
        applyStimulus(1'b0, mkEntry(64'h0, 1'b0), 1'b1, 1'b0);
        check1("drain valid", 64'(s_valid), 64'd0);
        check1("drain occupancy", 64'(s_occ), 64'd0);

        // Simultaneous push/pop at occupancy 2, across pointer wrap
        applyStimulus(1'b1, mkEntry(64'h8000_0200, 1'b0), 1'b0, 1'b0);
        applyStimulus(1'b1, mkEntry(64'h8000_0204, 1'b0), 1'b0, 1'b0);
        popped.delete();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, mkEntry(64'h8000_0208 + 64'(4 * k), 1'b0), 1'b1, 1'b0);
            check1("simul occupancy", 64'(s_occ), 64'd2);
        end
        check1("simul count", 64'(popped.size()), 64'd10);
        for (int k = 0; k < 10; k++)
            if (k < popped.size())
                check1("simul order", popped[k], 64'h8000_0200 + 64'(4 * k));
        applyStimulus(1'b0, mkEntry(64'h0, 1'b0), 1'b1, 1'b0);
        check1("simul final occupancy", 64'(s_occ), 64'd2);
        applyStimulus(1'b0, mkEntry(64'h0, 1'b0), 1'b1, 1'b0);

        // Exception lock
        exA = mkEntry(64'h8000_0300, 1'b1);
        applyStimulus(1'b1, exA, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, mkEntry(64'h8000_0304 + 64'(4 * j), 1'b0), 1'b0, 1'b0);
            check1("lock entry_ready_o", 64'(s_ready), 64'd0);
            check1("lock occupancy", 64'(s_occ), 64'd1);
        end
        popped.delete();
        applyStimulus(1'b1, mkEntry(64'h8000_0310, 1'b0), 1'b1, 1'b0);
        check1("lock fault valid", 64'(s_valid), 64'd1);
        check1("lock fault addr", s_addr, 64'h8000_0300);
        applyStimulus(1'b1, mkEntry(64'h8000_0314, 1'b0), 1'b1, 1'b0);
        check1("lock after drain valid", 64'(s_valid), 64'd0);
        check1("lock after drain ready", 64'(s_ready), 64'd0);
        check1("lock pops", 64'(popped.size()), 64'd1);
        applyStimulus(1'b1, mkEntry(64'h8000_0318, 1'b0), 1'b1, 1'b1);
        check1("lock flush ready", 64'(s_ready), 64'd0);
        applyStimulus(1'b0, mkEntry(64'h0, 1'b0), 1'b0, 1'b0);
        check1("lock cleared ready", 64'(s_ready), 64'd1);

        // Flush mid-stream with push and pop requested
        for (int j = 0; j < 3; j++)
            applyStimulus(1'b1, mkEntry(64'h8000_0400 + 64'(4 * j), 1'b0), 1'b0, 1'b0);
        applyStimulus(1'b1, mkEntry(64'h8000_04F0, 1'b0), 1'b1, 1'b1);
        check1("flush valid", 64'(s_valid), 64'd0);
        check1("flush occupancy before", 64'(s_occ), 64'd3);
        popped.delete();
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b0, mkEntry(64'h0, 1'b0), 1'b1, 1'b0);
            check1("flush occupancy after", 64'(s_occ), 64'd0);
        end
        check1("flush nothing popped", 64'(popped.size()), 64'd0);

        // Bypass / latency
        popped.delete();
        applyStimulus(1'b1, mkEntry(64'h8000_0100, 1'b0), 1'b1, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
        check1("bypass same-cycle valid", 64'(s_valid), 64'd1);
        check1("bypass same-cycle addr", s_addr, 64'h8000_0100);
        applyStimulus(1'b0, mkEntry(64'h0, 1'b0), 1'b1, 1'b0);
        check1("bypass occupancy", 64'(s_occ), 64'd0);
`else
        check1("latency first cycle valid", 64'(s_valid), 64'd0);
        applyStimulus(1'b0, mkEntry(64'h0, 1'b0), 1'b1, 1'b0);
        check1("latency second cycle valid", 64'(s_valid), 64'd1);
        check1("latency second cycle addr", s_addr, 64'h8000_0100);
        applyStimulus(1'b0, mkEntry(64'h0, 1'b0), 1'b1, 1'b0);
        check1("latency occupancy", 64'(s_occ), 64'd0);
`endif
        check1("bypass pops", 64'(popped.size()), 64'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) == 0)
                midReset();
            else
                applyStimulus($urandom_range(0, 99) < 70,
                              mkEntry({$urandom, $urandom}, $urandom_range(0, 99) < 3),
                              $urandom_range(0, 99) < 60,
                              $urandom_range(0, 99) < 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
